// File: rtl/harris_window_ctrl.sv
// harris_window_ctrl: sequences the eight center/neighbor squaring operations
// of a 3x3 window through an external datapath using a start/q handshake,
// and reports the final energy and the corner decision.
// Optional macro HARRIS_TIMEOUT_EN adds a watchdog on WAIT/RELEASE and the err port.
module harris_window_ctrl #(
    parameter logic [13:0] THRESH  = 14'd1024,
    parameter int unsigned TMO_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [71:0] win,
    output logic        busy,
    output logic        done,
    output logic [13:0] e_sum,
    output logic        corner,
    output logic        sq_start,
    output logic [7:0]  sq_center,
    output logic [7:0]  sq_target,
    output logic [13:0] sq_ein,
    input  logic        sq_q,
    input  logic [13:0] sq_eout
`ifdef HARRIS_TIMEOUT_EN
    ,
    output logic        err
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ISSUE   = 3'd2,
        WAIT    = 3'd3,
        RELEASE = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [71:0] r_win;
    logic [2:0]  r_idx;
    logic [13:0] r_e_acc;
    logic [13:0] r_e_sum;
    logic        r_corner;
    logic        w_tmo;
    logic [3:0]  w_pix;

`ifdef HARRIS_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);
    logic [15:0] r_tmo_cnt;
    logic        r_err;
    logic        w_tmo_hit;
    assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);
    assign err       = r_err;
`endif

    // Neighbor index 0..7 maps to pixel 0,1,2,3,5,6,7,8 (the center is skipped).
    assign w_pix     = (r_idx < 3'd4) ? {1'b0, r_idx} : ({1'b0, r_idx} + 4'd1);
    assign sq_center = r_win[39:32];
    assign sq_target = r_win[{w_pix, 3'b000} +: 8];
    assign sq_ein    = r_e_acc;
    assign sq_start  = (r_state == WAIT);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign e_sum     = r_e_sum;
    assign corner    = r_corner;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic; w_tmo flags a watchdog-forced exit to DONE.
    always_comb begin
        w_state_next = r_state;
        w_tmo        = 1'b0;
        case (r_state)
            IDLE:    if (start) w_state_next = LOAD;
            LOAD:    w_state_next = ISSUE;
            ISSUE:   w_state_next = WAIT;
            WAIT: begin
                if (sq_q) w_state_next = RELEASE;
`ifdef HARRIS_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    w_state_next = DONE;
                    w_tmo        = 1'b1;
                end
`endif
            end
            RELEASE: begin
                if (!sq_q) w_state_next = (r_idx == 3'd7) ? DONE : ISSUE;
`ifdef HARRIS_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    w_state_next = DONE;
                    w_tmo        = 1'b1;
                end
`endif
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Job datapath: latch window, track neighbor index, accumulate energy, publish result on DONE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win    <= '0;
            r_idx    <= '0;
            r_e_acc  <= '0;
            r_e_sum  <= '0;
            r_corner <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_win   <= win;
                    r_idx   <= '0;
                    r_e_acc <= '0;
                end
                WAIT:    if (sq_q) r_e_acc <= sq_eout;
                RELEASE: if (!sq_q && r_idx != 3'd7) r_idx <= r_idx + 3'd1;
                default: ;
            endcase
            if (w_state_next == DONE && r_state != DONE) begin
                r_e_sum  <= r_e_acc;
                r_corner <= w_tmo ? 1'b0 : (r_e_acc >= THRESH);
            end
        end
    end

`ifdef HARRIS_TIMEOUT_EN
    // Watchdog: counts cycles spent in WAIT/RELEASE, restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      r_tmo_cnt <= '0;
        else if (w_state_next != r_state) r_tmo_cnt <= '0;
        else if (r_state == WAIT || r_state == RELEASE) r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end

    // Error flag: set by a watchdog exit, cleared by the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        r_err <= 1'b0;
        else if (r_state == IDLE && start) r_err <= 1'b0;
        else if (w_tmo)                    r_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_harris_window_ctrl.sv
// Testbench for harris_window_ctrl: table of fixed windows, reset-mid-job and
// randomized jobs with a behavioural squaring-datapath model.
module tb_harris_window_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [71:0] win;
    logic        busy, done, corner, sq_start, sq_q;
    logic [13:0] e_sum, sq_ein, sq_eout;
    logic [7:0]  sq_center, sq_target;
`ifdef HARRIS_TIMEOUT_EN
    logic        err;
`endif

    harris_window_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .win(win),
        .busy(busy), .done(done), .e_sum(e_sum), .corner(corner),
        .sq_start(sq_start), .sq_center(sq_center), .sq_target(sq_target),
        .sq_ein(sq_ein), .sq_q(sq_q), .sq_eout(sq_eout)
`ifdef HARRIS_TIMEOUT_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    // Datapath model controls.
    int dp_lat   = 2;
    bit dp_never = 1'b0;
    int m_cnt;

    function automatic int sat_sq(int ein, int c, int t);
        int s;
        s = ein + (c - t) * (c - t);
        return (s > 16383) ? 16383 : s;
    endfunction

    // Squaring datapath model: q rises dp_lat cycles after start, falls one cycle after start falls.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0; sq_q <= 1'b0; sq_eout <= '0;
        end else if (sq_start) begin
            if (!sq_q && !dp_never) begin
                if (m_cnt + 1 >= dp_lat) begin
                    sq_q    <= 1'b1;
                    sq_eout <= 14'(sat_sq(int'(sq_ein), int'(sq_center), int'(sq_target)));
                end
                m_cnt <= m_cnt + 1;
            end
        end else begin
            m_cnt <= 0; sq_q <= 1'b0;
        end
    end

    int n_vec = 0, n_err = 0;
    int hs_cnt, done_cnt;
    bit prev_start = 1'b0;
    int ein_q[$];
    int ref_ein[8];
    int ref_esum;
    int ref_corner;

    task automatic chk(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    // Advance to the next falling edge and update the handshake monitor.
    task automatic tick();
        @(negedge clk);
        if (sq_start && !prev_start) begin
            hs_cnt++;
            ein_q.push_back(int'(sq_ein));
        end
        prev_start = sq_start;
        if (done) done_cnt++;
    endtask

    function automatic logic [71:0] mkwin(input int c, input int n);
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'((k == 4) ? c : n);
        return w;
    endfunction

    // Reference: sum of saturated squared center-neighbor differences over the 8 neighbors.
    task automatic ref_job(input logic [71:0] w);
        int acc, i, c;
        acc = 0; i = 0;
        c = int'(w[39:32]);
        for (int k = 0; k < 9; k++) begin
            if (k != 4) begin
                ref_ein[i] = acc;
                acc = sat_sq(acc, c, int'(w[k*8 +: 8]));
                i++;
            end
        end
        ref_esum   = acc;
        ref_corner = (acc >= 1024) ? 1 : 0;
    endtask

    task automatic run_job(input string name, input logic [71:0] w, input bit disturb);
        bit got_done;
        ref_job(w);
        hs_cnt = 0; done_cnt = 0; ein_q.delete();
        win = w; start = 1'b1;
        tick();
        start = 1'b0;
        chk({name, " busy_after_start"}, int'(busy), 1);
`ifdef HARRIS_TIMEOUT_EN
        chk({name, " err_cleared"}, int'(err), 0);
`endif
        got_done = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            tick();
            if (done) begin got_done = 1'b1; break; end
            if (disturb) begin
                start = 1'($urandom % 2);
                win   = {$urandom, $urandom, 8'($urandom)};
            end
        end
        start = 1'b0;
        chk({name, " done_seen"}, int'(got_done), 1);
        chk({name, " e_sum"}, int'(e_sum), ref_esum);
        chk({name, " corner"}, int'(corner), ref_corner);
        chk({name, " handshakes"}, hs_cnt, 8);
        for (int i = 0; i < 8 && i < ein_q.size(); i++)
            chk($sformatf("%s sq_ein[%0d]", name, i), ein_q[i], ref_ein[i]);
        tick();
        chk({name, " done_one_cycle"}, int'(done), 0);
        chk({name, " idle_busy"}, int'(busy), 0);
        tick();
        chk({name, " stays_idle"}, int'(busy), 0);
        chk({name, " done_pulses"}, done_cnt, 1);
        $display("job %s: e_sum=%0d corner=%0d handshakes=%0d (ref e_sum=%0d corner=%0d)",
                 name, e_sum, corner, hs_cnt, ref_esum, ref_corner);
    endtask

    typedef struct {
        string       name;
        logic [71:0] w;
        int          exp_esum;
        int          exp_corner;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [71:0] w;
        bit got;

        // Fixed vectors with hand-derived expectations.
        tbl[0] = '{"all100",      mkwin(100, 100), 0,     0};
        tbl[1] = '{"c10_n20",     mkwin(10, 20),   800,   0};
        tbl[2] = '{"c0_n20",      mkwin(0, 20),    3200,  1};
        tbl[3] = '{"c0_n255",     mkwin(0, 255),   16383, 1};
        tbl[4] = '{"c50_n18",     mkwin(50, 18),   8192,  1};
        w = mkwin(0, 0); w[7:0] = 8'd32;
        tbl[5] = '{"thresh_eq",   w,               1024,  1};
        w = mkwin(0, 0); w[7:0] = 8'd31; w[15:8] = 8'd7; w[23:16] = 8'd3; w[31:24] = 8'd2;
        tbl[6] = '{"thresh_m1",   w,               1023,  0};
        tbl[7] = '{"c200_n0",     mkwin(200, 0),   16383, 1};

        start = 1'b0; win = '0; rst_n = 1'b1;
        #3 rst_n = 1'b0;
        tick(); tick();
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst sq_start", int'(sq_start), 0);
        chk("rst e_sum", int'(e_sum), 0);
        chk("rst corner", int'(corner), 0);
        chk("rst sq_ein", int'(sq_ein), 0);
`ifdef HARRIS_TIMEOUT_EN
        chk("rst err", int'(err), 0);
`endif
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 8; v++) begin
            run_job(tbl[v].name, tbl[v].w, 1'b0);
            chk({tbl[v].name, " table_e_sum"}, int'(e_sum), tbl[v].exp_esum);
            chk({tbl[v].name, " table_corner"}, int'(corner), tbl[v].exp_corner);
        end

        // Reset during the 4th WAIT, then a fresh job.
        hs_cnt = 0; ein_q.delete();
        win = mkwin(0, 20); start = 1'b1;
        tick();
        start = 1'b0;
        got = 1'b0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            tick();
            if (hs_cnt == 4 && sq_start) begin got = 1'b1; break; end
        end
        chk("midjob reached_wait4", int'(got), 1);
        rst_n = 1'b0;
        #1;
        chk("midjob busy", int'(busy), 0);
        chk("midjob sq_start", int'(sq_start), 0);
        chk("midjob e_sum", int'(e_sum), 0);
        chk("midjob corner", int'(corner), 0);
        chk("midjob sq_ein", int'(sq_ein), 0);
        chk("midjob sq_center", int'(sq_center), 0);
        chk("midjob sq_target", int'(sq_target), 0);
        tick(); tick();
        chk("midjob done_held", int'(done), 0);
        rst_n = 1'b1;
        tick();
        run_job("after_reset", mkwin(0, 20), 1'b0);

        // Random windows, random datapath latency, junk start/win while busy.
        for (int r = 0; r < 20; r++) begin
            dp_lat = 1 + int'($urandom_range(3));
            w = {$urandom, $urandom, 8'($urandom)};
            if (r % 4 == 0) w[39:32] = w[7:0] + 8'($urandom_range(15));
            run_job($sformatf("rand%0d", r), w, 1'b1);
        end
        dp_lat = 2;

`ifdef HARRIS_TIMEOUT_EN
        // Watchdog: datapath never answers.
        begin
            int wait_cyc;
            bit seen_wait;
            dp_never = 1'b1;
            hs_cnt = 0; done_cnt = 0; ein_q.delete();
            win = mkwin(0, 50); start = 1'b1;
            tick();
            start = 1'b0;
            got = 1'b0; seen_wait = 1'b0; wait_cyc = 0;
            for (int cyc = 0; cyc < 500; cyc++) begin
                tick();
                if (done) begin got = 1'b1; break; end
                if (sq_start) seen_wait = 1'b1;
                if (seen_wait) wait_cyc++;
                start = 1'($urandom % 2);
            end
            start = 1'b0;
            chk("tmo done_seen", int'(got), 1);
            chk("tmo wait_cycles", wait_cyc, 16);
            chk("tmo err", int'(err), 1);
            chk("tmo e_sum", int'(e_sum), 0);
            chk("tmo corner", int'(corner), 0);
            chk("tmo handshakes", hs_cnt, 1);
            tick(); tick();
            chk("tmo idle", int'(busy), 0);
            chk("tmo err_held", int'(err), 1);
            $display("job timeout: err=%0d e_sum=%0d wait_cycles=%0d", err, e_sum, wait_cyc);
            dp_never = 1'b0;
            run_job("after_tmo", mkwin(10, 20), 1'b0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/harris_window_ctrl.md
HARRIS_WINDOW_CTRL -- requirements
Module: harris_window_ctrl

Interface
REQ-001 Parameter THRESH, default 14'd1024, corner threshold compared against the final e_sum.
REQ-002 Parameter TMO_CYC, default 16, watchdog limit in cycles (used only with HARRIS_TIMEOUT_EN).
REQ-003 clk  in  1  rising-edge clock, the only clock.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  request to process the window; sampled only in IDLE.
REQ-006 win  in  72  3x3 pixel window, row-major, pixel k at bits [8k+7:8k], center k=4.
REQ-007 busy  out  1  high in every state except IDLE.
REQ-008 done  out  1  one-cycle pulse when e_sum/corner are valid.
REQ-009 e_sum  out  14  final accumulated energy, held until the next done.
REQ-010 corner  out  1  e_sum >= THRESH, updated with done.
REQ-011 sq_start  out  1  request to the squaring datapath.
REQ-012 sq_center  out  8  center pixel driven to the datapath.
REQ-013 sq_target  out  8  current neighbor pixel driven to the datapath.
REQ-014 sq_ein  out  14  running energy driven to the datapath.
REQ-015 sq_q  in  1  datapath completion flag; may rise any number of cycles after sq_start.
REQ-016 sq_eout  in  14  datapath result, valid while sq_q is high.
REQ-017 err  out  1  timeout flag; present only with HARRIS_TIMEOUT_EN.

Function
REQ-018 FSM states: IDLE, LOAD, ISSUE, WAIT, RELEASE, DONE.
REQ-019 IDLE -> LOAD when start=1: latch win into an internal 72-bit register, clear e_acc to 0, and set the neighbor index to 0.
REQ-020 LOAD -> ISSUE: skip index 4; neighbor order is 0,1,2,3,5,6,7,8 (8 operations).
REQ-021 ISSUE -> WAIT: assert sq_start and drive sq_center=pixel4, sq_target=pixel[idx], sq_ein=e_acc; keep all four stable through WAIT.
REQ-022 In WAIT, when sq_q=1: capture sq_eout into e_acc, drop sq_start next cycle, and go to RELEASE.
REQ-023 In RELEASE, wait for sq_q=0; then advance idx to ISSUE, or go to DONE after the 8th neighbor.
REQ-024 DONE: e_sum<=e_acc, corner<=(e_acc>=THRESH), done=1 for exactly one cycle, then go to IDLE.
REQ-025 start is ignored in every state other than IDLE, including DONE; changes on win after LOAD do not affect the current job.
REQ-026 e_acc is taken verbatim from sq_eout; the controller does no arithmetic on it other than the unsigned 14-bit compare.
REQ-027 Minimum latency with a 1-cycle sq_q response: start to done = 1+8x(1+1+1)+1 = 26 cycles.
REQ-028 busy=0 only in IDLE; sq_start=0 in IDLE, LOAD, RELEASE and DONE.

Reset
REQ-029 On rst_n=0, at any time including mid-job: go to IDLE; busy, done, sq_start, corner and err = 0; e_sum, e_acc, sq_ein, sq_center and sq_target = 0.
REQ-030 After rst_n deasserts, the first job starts with e_acc=0 and idx=0; no partial job resumes.

Configuration
REQ-031 Macro HARRIS_TIMEOUT_EN defined: a counter runs in WAIT and RELEASE and clears on each state entry; when it reaches TMO_CYC, the FSM goes to DONE with err=1, e_sum=e_acc and corner=0.
REQ-032 err clears on the next accepted start; errors take priority over the corner evaluation.
REQ-033 Macro not defined: no err port and no counter; WAIT and RELEASE wait indefinitely.

Verification
REQ-034 Bench datapath model: sq_q rises 2 cycles after sq_start, sq_eout = min(sq_ein+(center-target)^2, 16383), and sq_q falls 1 cycle after sq_start falls.
REQ-035 All pixels 100, start pulse -> exactly 8 sq_start handshakes, e_sum=0, corner=0, one done pulse.
REQ-036 Center 10, neighbors 20 -> sq_ein sequence 0,100,...,700; e_sum=800; corner=0.
REQ-037 Center 0, neighbors 20 -> e_sum=3200, corner=1; center 0, neighbors 255 -> e_sum=16383, corner=1.
REQ-038 rst_n pulsed low during the 4th WAIT, then a new start -> all outputs read 0 during reset, and the new job gives the correct e_sum with 8 handshakes.
REQ-039 HARRIS_TIMEOUT_EN, model never raises sq_q -> done and err=1 after TMO_CYC cycles in WAIT, e_sum=0; a start pulse while busy is ignored.
